// File: rtl/alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl
//  Description : Multi-cycle controller for a small 4 x 8-bit register
//                machine. It fetches an instruction word, handles moves and
//                NOPs itself, and runs the other opcodes through an external
//                combinational ALU with a LOADA / EXEC / WBACK sequence.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          : clock, all state changes on its rising edge
//    rst          : asynchronous active-high reset
//    i_run        : instruction request, sampled only while idle
//    i_instr      : instruction word {op[7:4], rx[3:2], ry[1:0]}
//    i_din        : immediate data for MVI, captured with i_instr
//    i_alu_result : result from the downstream ALU
//    i_rd_sel     : debug register select
//    o_alu_inst   : ALU opcode (IR[7:4])
//    o_a          : ALU A operand (A register)
//    o_bus_wires  : ALU B operand, R[ry] during EXEC, otherwise zero
//    o_done       : one-cycle pulse in the final state of an instruction
//    o_busy       : high whenever the controller is not idle
//    o_rd_data    : combinational R[i_rd_sel]
// ============================================================================
module alu_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run,
  input  logic [7:0] i_instr,
  input  logic [7:0] i_din,
  input  logic [7:0] i_alu_result,
  input  logic [1:0] i_rd_sel,
  output logic [3:0] o_alu_inst,
  output logic [7:0] o_a,
  output logic [7:0] o_bus_wires,
  output logic       o_done,
  output logic       o_busy,
  output logic [7:0] o_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOADA = 2'd1,
    S_EXEC  = 2'd2,
    S_WBACK = 2'd3
  } state_t;

  localparam logic [3:0] c_OP_MVI  = 4'b0001;
  localparam logic [3:0] c_OP_MV   = 4'b1000;
  localparam logic [3:0] c_OP_NOP0 = 4'b1001;
  localparam logic [3:0] c_OP_NOP1 = 4'b1111;

  state_t     r_state;
  logic [7:0] r_reg [4];
  logic [7:0] r_ir;
  logic [7:0] r_dr;
  logic [7:0] r_a;
  logic [7:0] r_g;
  logic       r_done;
  logic       r_busy;

  logic [3:0] w_op;
  logic [1:0] w_rx;
  logic [1:0] w_ry;

  assign w_op = r_ir[7:4];
  assign w_rx = r_ir[3:2];
  assign w_ry = r_ir[1:0];

  // Opcodes that complete in LOADA without touching the ALU.
  function automatic logic is_short(input logic [3:0] op);
    return (op == c_OP_MVI) || (op == c_OP_MV) ||
           (op == c_OP_NOP0) || (op == c_OP_NOP1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      for (int i = 0; i < 4; i++) begin
        r_reg[i] <= 8'h00;
      end
      r_ir   <= 8'h00;
      r_dr   <= 8'h00;
      r_a    <= 8'h00;
      r_g    <= 8'h00;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_ir    <= i_instr;
            r_dr    <= i_din;
            r_state <= S_LOADA;
            r_busy  <= 1'b1;
            // Done is registered: it must already be high in LOADA when
            // LOADA is the final state of this instruction.
            r_done  <= is_short(i_instr[7:4]);
          end
        end

        S_LOADA: begin
          r_done <= 1'b0;
          if (is_short(w_op)) begin
            if (w_op == c_OP_MVI) begin
              r_reg[w_rx] <= r_dr;
            end else if (w_op == c_OP_MV) begin
              r_reg[w_rx] <= r_reg[w_ry];
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_a     <= r_reg[w_rx];
            r_state <= S_EXEC;
          end
        end

        S_EXEC: begin
          r_g     <= i_alu_result;
          r_state <= S_WBACK;
          r_done  <= 1'b1;
        end

        S_WBACK: begin
          r_reg[w_rx] <= r_g;
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_alu_inst  = w_op;
  assign o_a         = r_a;
  assign o_bus_wires = (r_state == S_EXEC) ? r_reg[w_ry] : 8'h00;
  assign o_done      = r_done;
  assign o_busy      = r_busy;
  assign o_rd_data   = r_reg[i_rd_sel];

endmodule
`default_nettype wire
